// File: rtl/stream_cipher_pkg.sv
// stream_cipher_pkg: shared constants, LFSR step and rx state encoding for the stream cipher pair.
package stream_cipher_pkg;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int BYTE_W = 8;
    // Taps at bits 7,5,4,3 feed the new LSB
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {HUNT, SEED, LEN, PAYLOAD, CHK} rx_state_t;

    function automatic logic [7:0] lfsr8_step(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction
endpackage

// File: rtl/keystream_lfsr8.sv
// keystream_lfsr8: per-frame reseedable 8-bit keystream; a zero seed becomes 8'h01 to avoid lock-up.
module keystream_lfsr8
    import stream_cipher_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] key
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            key <= 8'h01;
        else if (load)
            key <= (seed == 8'h00) ? 8'h01 : seed;
        else if (step)
            key <= lfsr8_step(key);
    end
endmodule

// File: rtl/stream_decrypt_rx.sv
// stream_decrypt_rx: parses SYNC/SEED/LEN/payload frames and XORs the LFSR keystream out of the payload.
// Optional trailing checksum byte and chk_err port with STREAM_DECRYPT_CHKSUM_EN.
module stream_decrypt_rx
    import stream_cipher_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT,
    parameter int         DATA_W    = BYTE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_done,
`ifdef STREAM_DECRYPT_CHKSUM_EN
    output logic              chk_err,
`endif
    output logic              sync_err
);
`ifdef STREAM_DECRYPT_CHKSUM_EN
    localparam rx_state_t END_ST = CHK;
`else
    localparam rx_state_t END_ST = HUNT;
`endif

    rx_state_t   state, state_nx;
    logic [7:0]  count, key;
    logic        accept, ld_key, pay, last_nx, fd_nx, se_nx;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    keystream_lfsr8 u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (ld_key),
        .seed (in_data),
        .step (pay),
        .key  (key)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= HUNT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (accept) begin
            case (state)
                HUNT:    state_nx = (in_data == SYNC_BYTE) ? SEED : HUNT;
                SEED:    state_nx = LEN;
                LEN:     state_nx = (in_data == 8'd0) ? END_ST : PAYLOAD;
                PAYLOAD: state_nx = (count == 8'd1) ? END_ST : PAYLOAD;
                default: state_nx = HUNT;
            endcase
        end
    end

    always_comb begin
        pay     = accept && state == PAYLOAD;
        ld_key  = accept && state == SEED;
        last_nx = count == 8'd1;
        se_nx   = accept && state == HUNT && in_data != SYNC_BYTE;
`ifdef STREAM_DECRYPT_CHKSUM_EN
        fd_nx   = accept && state == CHK;
`else
        fd_nx   = (accept && state == LEN && in_data == 8'd0) || (pay && last_nx);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= 8'd0;
        else if (accept && state == LEN)
            count <= in_data;
        else if (pay)
            count <= count - 8'd1;
    end

    // A new payload byte reloads the register even while the old one drains, so no bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            frame_done <= fd_nx;
            sync_err   <= se_nx;
            if (pay) begin
                out_valid <= 1'b1;
                out_data  <= in_data ^ key;
                out_last  <= last_nx;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

`ifdef STREAM_DECRYPT_CHKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum    <= 8'd0;
            chk_err <= 1'b0;
        end else begin
            chk_err <= accept && state == CHK && in_data != csum;
            if (ld_key)
                csum <= 8'd0;
            else if (pay)
                csum <= csum ^ in_data ^ key;
        end
    end
`endif
endmodule

// File: tb/tb_stream_decrypt_rx.sv
// tb_stream_decrypt_rx: directed frames with hand-computed plaintext, stall, resync and reset checks.
module tb_stream_decrypt_rx;
    logic       clk = 0, rst_n = 0, in_valid = 0, out_ready = 1;
    logic [7:0] in_data = 0, out_data;
    logic       in_ready, out_valid, out_last, frame_done, sync_err;
`ifdef STREAM_DECRYPT_CHKSUM_EN
    logic       chk_err;
    localparam bit CHK = 1;
`else
    localparam bit CHK = 0;
`endif

    int tests = 0, fails = 0, cyc = 0;
    int fd_cnt = 0, se_cnt = 0, fdl_cnt = 0, ov_cnt = 0;
    logic [7:0] q_data[$];
    logic       q_last[$];
    int         q_cyc[$];
    int n0, f0, s0, v0, l0;

    stream_decrypt_rx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .frame_done(frame_done),
`ifdef STREAM_DECRYPT_CHKSUM_EN
        .chk_err   (chk_err),
`endif
        .sync_err  (sync_err)
    );

    always #5 clk = ~clk;

    // Inputs change #1 after posedge, so the negedge sees what the next edge will use.
    always @(negedge clk) begin
        cyc++;
        if (frame_done) fd_cnt++;
        if (sync_err) se_cnt++;
        if (out_valid) ov_cnt++;
        if (frame_done && out_valid && out_last) fdl_cnt++;
        if (out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
            q_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1;
        in_data  = b;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 0;
                return;
            end
        end
        check("send_timeout", 0, 1);
        in_valid = 0;
    endtask

    task automatic end_frame(input logic [7:0] cs);
        if (CHK) send(cs);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst_n = 1;
        idle(1);

        // Seed 01: keystream 01,02 -> 41^01, 42^02
        n0 = q_data.size(); f0 = fd_cnt; l0 = fdl_cnt;
        send(8'hA5); send(8'h01); send(8'h02); send(8'h41); send(8'h42);
        end_frame(8'h00);
        check("t1_fd_now", frame_done, 1);
        idle(3);
        check("t1_count", q_data.size(), n0 + 2);
        check("t1_d0", q_data[n0], 8'h40);
        check("t1_d1", q_data[n0+1], 8'h40);
        check("t1_last0", q_last[n0], 0);
        check("t1_last1", q_last[n0+1], 1);
        check("t1_b2b", q_cyc[n0+1] - q_cyc[n0], 1);
        check("t1_fd_pulses", fd_cnt - f0, 1);
        check("t1_fd_with_last", fdl_cnt - l0, CHK ? 0 : 1);

        // Seed 80: keystream 80,01
        n0 = q_data.size();
        send(8'hA5); send(8'h80); send(8'h02); send(8'h80); send(8'h01);
        end_frame(8'h00);
        idle(2);
        check("t2_count", q_data.size(), n0 + 2);
        check("t2_d0", q_data[n0], 8'h00);
        check("t2_d1", q_data[n0+1], 8'h00);

        // Garbage before sync, then an empty frame
        s0 = se_cnt; f0 = fd_cnt; v0 = ov_cnt;
        send(8'h33); send(8'h44); send(8'hA5); send(8'h00); send(8'h00);
        end_frame(8'h00);
        check("t3_fd_now", frame_done, 1);
        idle(2);
        check("t3_sync_err", se_cnt - s0, 2);
        check("t3_fd_pulses", fd_cnt - f0, 1);
        check("t3_no_valid", ov_cnt - v0, 0);

        // Zero seed must behave as seed 01
        n0 = q_data.size();
        send(8'hA5); send(8'h00); send(8'h01); send(8'h80);
        end_frame(8'h81);
        idle(2);
        check("t3z_count", q_data.size(), n0 + 1);
        check("t3z_d0", q_data[n0], 8'h81);
        check("t3z_last", q_last[n0], 1);

        // Seed 03 keystream 03,06,0C with downstream stalled
        n0 = q_data.size();
        out_ready = 0;
        fork
            begin
                send(8'hA5); send(8'h03); send(8'h03);
                send(8'h10); send(8'h20); send(8'h30);
                end_frame(8'h09);
            end
            begin
                for (int i = 0; i < 64 && !out_valid; i++) @(negedge clk);
                check("t4_valid_seen", out_valid, 1);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("t4_stall_ready", in_ready, 0);
                    check("t4_stall_valid", out_valid, 1);
                    check("t4_stall_data", out_data, 8'h13);
                    check("t4_stall_last", out_last, 0);
                end
                @(posedge clk); #1;
                out_ready = 1;
            end
        join
        idle(3);
        check("t4_count", q_data.size(), n0 + 3);
        check("t4_d0", q_data[n0], 8'h13);
        check("t4_d1", q_data[n0+1], 8'h26);
        check("t4_d2", q_data[n0+2], 8'h3C);
        check("t4_last", {q_last[n0], q_last[n0+1], q_last[n0+2]}, 3'b001);

        // Reset in mid-frame drops the partial frame
        send(8'hA5); send(8'h03); send(8'h03); send(8'h10);
        rst_n = 0;
        @(negedge clk);
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_last", out_last, 0);
        check("t5_rst_fd", frame_done, 0);
        check("t5_rst_se", sync_err, 0);
        @(posedge clk); #1;
        rst_n = 1;
        idle(1);
        n0 = q_data.size();
        send(8'hA5); send(8'h01); send(8'h01); send(8'hFF);
        end_frame(8'hFE);
        idle(2);
        check("t5_count", q_data.size(), n0 + 1);
        check("t5_d0", q_data[n0], 8'hFE);
        check("t5_last", q_last[n0], 1);

`ifdef STREAM_DECRYPT_CHKSUM_EN
        send(8'hA5); send(8'h01); send(8'h02); send(8'h41); send(8'h42);
        check("c1_fd_early", frame_done, 0);
        send(8'h00);
        check("c1_fd", frame_done, 1);
        check("c1_chk_err", chk_err, 0);
        idle(2);
        send(8'hA5); send(8'h01); send(8'h02); send(8'h41); send(8'h42);
        check("c2_err_early", chk_err, 0);
        send(8'h01);
        check("c2_fd", frame_done, 1);
        check("c2_chk_err", chk_err, 1);
        idle(2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/stream_decrypt_rx.md
Name: stream_decrypt_rx

Overview:
Receive-side counterpart of the stream encryptor.
- Parses an incoming byte stream framed as SYNC, SEED, LEN, then LEN ciphertext bytes.
- Reseeds an 8-bit LFSR keystream per frame and XORs it out of the payload.
- Emits plaintext on a valid/ready interface.
- Sits between the link byte receiver and the application consumer.

Parameters:
SYNC_BYTE, 8'hA5, frame delimiter value.
DATA_W, 8, byte width. Fixed at 8; present for package consistency only.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  upstream byte valid.
in_data  in  8  upstream byte: header or ciphertext.
in_ready  out  1  byte accepted when in_valid && in_ready.
out_valid  out  1  plaintext byte valid.
out_data  out  8  plaintext byte.
out_last  out  1  qualifies the last payload byte of a frame.
out_ready  in  1  downstream accept.
frame_done  out  1  one-cycle pulse when a frame completes.
sync_err  out  1  one-cycle pulse per non-SYNC byte discarded while hunting.

Behaviour:
- Reset (async, rst_n=0):
  - State = HUNT; key = 8'h01; count = 0.
  - out_valid, out_data, out_last, frame_done, sync_err all = 0.
  - Applies mid-frame too; any partial frame is dropped.
- in_ready = !out_valid || out_ready. It is combinational and holds in every state, so header bytes also stall while output is blocked.
- Accept = in_valid && in_ready. State, key and counter change only on an accept.
- LFSR step(q) = {q[6:0], q[7]^q[5]^q[4]^q[3]}.
- FSM:
  - HUNT:
    - Byte == SYNC_BYTE -> SEED.
    - Otherwise pulse sync_err the next cycle and stay in HUNT.
  - SEED: key <= byte, except 8'h00 is replaced by 8'h01 (LFSR lock-up guard). -> LEN.
  - LEN:
    - byte == 0 -> HUNT, and frame_done pulses the next cycle.
    - Otherwise count <= byte -> PAYLOAD.
  - PAYLOAD, on each accept:
    - out_data <= byte ^ key; out_valid <= 1.
    - out_last <= (count == 1).
    - key <= step(key); count <= count - 1.
    - When count == 1: -> HUNT, and frame_done pulses in the same cycle that out_last first appears.
- Keystream alignment: payload byte i uses step^i(seed), so byte 0 uses the seed itself. This matches the encryptor's load-then-advance order.
- Latency: exactly 1 clock from accept to out_valid/out_data.
- Output register:
  - out_valid clears when out_ready is high and no new payload byte is accepted that cycle.
  - out_data and out_last hold stable while out_valid && !out_ready.
- Simultaneous out_ready and new accept: the register reloads, giving back-to-back valid bytes with no bubble.
- SYNC-valued bytes inside the payload are treated as data and do not resync.
- Count is 8 bits, so frames are 1..255 bytes long.

Optional Feature:
Macro STREAM_DECRYPT_CHKSUM_EN.
- Defined:
  - After the last payload byte, the FSM enters CHK and accepts one unencrypted checksum byte, equal to the XOR of all plaintext bytes of the frame.
  - Adds output port chk_err (1 bit). It pulses together with frame_done on a mismatch.
  - frame_done moves to the cycle after the CHK accept.
  - out_last timing is unchanged.
  - For LEN=0 the CHK byte is still expected and must be 8'h00.
- Undefined:
  - No CHK state and no chk_err port.
  - Behaviour is exactly as specified above.

Decomposition:
- Package stream_cipher_pkg:
  - default SYNC_BYTE;
  - LFSR tap constant and lfsr8_step function (shared with the encryptor);
  - rx state enum {HUNT, SEED, LEN, PAYLOAD, CHK}.
- One sub-module, keystream_lfsr8, with ports clk, rst_n, load, seed, step, key. It owns the zero-seed substitution.
- FSM, counter and output register stay in stream_decrypt_rx.

Test Plan:
- Bytes A5,01,02,41,42 with out_ready=1 -> out_data 40 then 40 on consecutive cycles; out_last on the second byte; one frame_done pulse aligned with out_last.
- Seed 80, LEN 02, cipher 80,01 -> plaintext 00,00 (keystream 80 then 01).
- Leading bytes 33,44 then A5,00,00 -> two sync_err pulses; frame_done one cycle after LEN accept; out_valid never asserts. Seed 00 is replaced by 01.
- LEN 03 with out_ready held low for 5 cycles -> in_ready low while out_valid; out_data stable; no byte lost or duplicated after release.
- rst_n pulsed low after 1 of 3 payload bytes, then a new frame A5,01,01,FF -> all outputs 0 during reset; new frame gives FE with out_last.
- CHKSUM_EN: A5,01,02,41,42,00 -> no chk_err. Replacing the last byte with 01 -> chk_err pulses with frame_done, one cycle after the CHK accept.
